// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared mode type and cyclic priority search for stream_mux_n_1
//
// Purpose : mode encoding (fixed select vs round-robin) and the
//           combinational cyclic search used by the round-robin arbiter.
// Ports   : none (package).
package mux_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mux_mode_e;

    // Finds the first set bit of req[n-1:0], visiting ptr+1, ptr+2, ... (mod n).
    // The request word is fixed at 64 bits, the largest channel count supported.
    // Loop runs from the farthest offset to the nearest, so the nearest hit is
    // the one that survives.
    function automatic logic rr_search(
        input  logic [63:0] req,
        input  logic [6:0]  n,
        input  logic [6:0]  ptr,
        output logic [5:0]  idx
    );
        logic       found;
        logic [6:0] k;
        found = 1'b0;
        idx   = '0;
        for (int i = 64; i >= 1; i--) begin
            if (7'(i) <= n) begin
                k = ptr + 7'(i);
                if (k >= n) begin
                    k = k - n;
                end
                if (req[k[5:0]]) begin
                    found = 1'b1;
                    idx   = k[5:0];
                end
            end
        end
        return found;
    endfunction

endpackage

// File: rtl/rr_arbiter_n.sv
// rtl/rr_arbiter_n.sv - combinational round-robin grant search
//
// Purpose : picks the first requesting channel after ptr, cyclically.
// Ports   : req     - N request bits
//           ptr     - index of the most recently granted channel
//           gnt_idx - chosen channel index (valid when gnt_any)
//           gnt_any - at least one request present
module rr_arbiter_n
    import mux_pkg::*;
#(
    parameter int N = 8,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] gnt_idx,
    output logic         gnt_any
);

    logic [5:0] idx_wide;

    always_comb begin
        idx_wide = '0;
        gnt_any  = rr_search(64'(req), 7'(N), 7'(ptr), idx_wide);
        gnt_idx  = W'(idx_wide);
    end

endmodule

// File: rtl/stream_mux_n_1.sv
// rtl/stream_mux_n_1.sv - N-to-1 valid/ready stream mux with registered output
//
// Purpose : selects one of N_IN producer channels, either by sel (fixed mode)
//           or round-robin, and registers the beat toward one consumer.
//           Full throughput: a draining beat may be replaced in the same cycle.
// Ports   : clk, rst_n           - clock, asynchronous active-low reset
//           in_data/in_valid     - N_IN packed producer channels
//           in_ready             - combinational per-channel ready
//           mode, sel            - 0 = fixed (use sel), 1 = round-robin
//           out_data/out_valid   - registered output beat
//           out_ready            - downstream ready
//           grant_idx            - channel that produced out_data
//           beat_count           - 16-bit wrapping transfer counter, present
//                                  only when STREAM_MUX_COUNT_EN is defined
module stream_mux_n_1
    import mux_pkg::*;
#(
    parameter int N_IN  = 8,
    parameter int WIDTH = 8,
    parameter int SEL_W = $clog2(N_IN)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_IN*WIDTH-1:0] in_data,
    input  logic [N_IN-1:0]       in_valid,
    output logic [N_IN-1:0]       in_ready,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SEL_W-1:0]      grant_idx
`ifdef STREAM_MUX_COUNT_EN
    ,
    output logic [15:0]           beat_count
`endif
);

    logic             free;
    logic             accept;
    logic             rr_any;
    logic             chosen_any;
    logic [SEL_W-1:0] rr_idx;
    logic [SEL_W-1:0] chosen;
    logic [SEL_W-1:0] rr_ptr;

    rr_arbiter_n #(
        .N (N_IN),
        .W (SEL_W)
    ) u_arb (
        .req     (in_valid),
        .ptr     (rr_ptr),
        .gnt_idx (rr_idx),
        .gnt_any (rr_any)
    );

    assign free = !out_valid || out_ready;

    // Fixed mode: an out-of-range sel (non power-of-two N_IN) chooses nothing.
    always_comb begin
        chosen     = sel;
        chosen_any = (int'(sel) < N_IN);
        if (mux_mode_e'(mode) == MODE_RR) begin
            chosen     = rr_idx;
            chosen_any = rr_any;
        end
    end

    // Ready is held low while in reset so no producer sees a phantom handshake.
    always_comb begin
        for (int k = 0; k < N_IN; k++) begin
            in_ready[k] = rst_n && free && chosen_any && (chosen == SEL_W'(k));
        end
    end

    assign accept = |(in_valid & in_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            grant_idx <= '0;
            rr_ptr    <= SEL_W'(N_IN - 1);
        end else begin
            if (accept) begin
                out_data  <= in_data[chosen*WIDTH +: WIDTH];
                grant_idx <= chosen;
                out_valid <= 1'b1;
                if (mux_mode_e'(mode) == MODE_RR) begin
                    rr_ptr <= chosen;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef STREAM_MUX_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_count <= '0;
        end else if (out_valid && out_ready) begin
            beat_count <= beat_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_stream_mux_n_1.sv
// tb/tb_stream_mux_n_1.sv - self-checking bench for stream_mux_n_1
module tb_stream_mux_n_1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] in_data;
    logic [7:0]  in_valid;
    logic [7:0]  in_ready;
    logic        mode;
    logic [2:0]  sel;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  grant_idx;

    logic [71:0] in9_data;
    logic [8:0]  in9_valid;
    logic [8:0]  in9_ready;
    logic [3:0]  sel9;
    logic [7:0]  out9_data;
    logic        out9_valid;
    logic [3:0]  grant9;
`ifdef STREAM_MUX_COUNT_EN
    logic [15:0] beat_count;
    logic [15:0] beat9;
`endif

    int checks = 0;
    int errors = 0;

    logic       m_valid;
    logic [7:0] m_data;
    logic [2:0] m_grant;
    logic [2:0] m_ptr;
    logic [15:0] m_count;

    always #5 clk = ~clk;

    stream_mux_n_1 #(.N_IN(8), .WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .grant_idx (grant_idx)
`ifdef STREAM_MUX_COUNT_EN
        ,
        .beat_count(beat_count)
`endif
    );

    stream_mux_n_1 #(.N_IN(9), .WIDTH(8)) dut9 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in9_data),
        .in_valid  (in9_valid),
        .in_ready  (in9_ready),
        .mode      (1'b0),
        .sel       (sel9),
        .out_data  (out9_data),
        .out_valid (out9_valid),
        .out_ready (1'b1),
        .grant_idx (grant9)
`ifdef STREAM_MUX_COUNT_EN
        ,
        .beat_count(beat9)
`endif
    );

    // Reference model: expected ready word from the selection rules.
    function automatic logic [7:0] exp_ready();
        if (rst_n !== 1'b1) return 8'h00;
        if (m_valid && !out_ready) return 8'h00;
        if (mode == 1'b0) return 8'(1) << sel;
        for (int off = 1; off <= 8; off++) begin
            int k;
            k = (int'(m_ptr) + off) % 8;
            if (in_valid[k]) return 8'(1) << k;
        end
        return 8'h00;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = 8'h00;
        m_grant = 3'd0;
        m_ptr   = 3'd7;
        m_count = 16'd0;
    endtask

    // Advance the model by one clock edge and move to the next sampling point.
    task automatic tick();
        logic [7:0] acc;
        acc = exp_ready() & in_valid;
        if (m_valid && out_ready) m_count = m_count + 16'd1;
        if (acc != 8'h00) begin
            for (int k = 0; k < 8; k++) begin
                if (acc[k]) begin
                    m_valid = 1'b1;
                    m_data  = in_data[k*8 +: 8];
                    m_grant = 3'(k);
                    if (mode) m_ptr = 3'(k);
                end
            end
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [7:0] er;
        rst_n     = 1'b0;
        in_data   = {$urandom, $urandom};
        in_valid  = 8'($urandom);
        mode      = 1'($urandom);
        sel       = 3'($urandom);
        out_ready = 1'($urandom);
        @(posedge clk);
        @(negedge clk);
        model_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
        checks++; if (grant_idx !== 3'd0) begin errors++; $display("FAIL reset_grant got=%0d exp=0", grant_idx); end
        checks++; if (in_ready !== 8'h00) begin errors++; $display("FAIL reset_in_ready got=%b exp=00000000", in_ready); end
        rst_n    = 1'b1;
        mode     = 1'b0;
        in_valid = 8'h00;
        sel      = 3'($urandom);
        #1;
        er = 8'(1) << sel;
        checks++; if (in_ready !== er) begin errors++; $display("FAIL reset_release_ready got=%b exp=%b", in_ready, er); end
    endtask

    task automatic test_fixed();
        mode      = 1'b0;
        sel       = 3'd3;
        in_data   = {$urandom, $urandom};
        in_data[3*8 +: 8] = 8'hA5;
        in_valid  = 8'h08;
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 8'h08) begin errors++; $display("FAIL fixed_ready got=%b exp=00001000", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fixed_out_valid got=%b exp=1", out_valid); end
        checks++; if (out_data !== 8'hA5) begin errors++; $display("FAIL fixed_out_data got=%h exp=a5", out_data); end
        checks++; if (grant_idx !== 3'd3) begin errors++; $display("FAIL fixed_grant got=%0d exp=3", grant_idx); end
        in_valid = 8'h00;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fixed_drain_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 8'hA5) begin errors++; $display("FAIL fixed_drain_hold got=%h exp=a5", out_data); end
    endtask

    task automatic test_sel_range();
        logic [8:0] er;
        in9_valid = 9'h1FF;
        in9_data  = {8'h11, $urandom, $urandom};
        for (int s = 0; s < 16; s++) begin
            sel9 = 4'(s);
            #1;
            er = (s < 9) ? (9'(1) << s) : 9'h000;
            checks++; if (in9_ready !== er) begin errors++; $display("FAIL sel_range_%0d got=%b exp=%b", s, in9_ready, er); end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        mode      = 1'b0;
        sel       = 3'd3;
        in_data[3*8 +: 8] = 8'hA5;
        in_valid  = 8'h08;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_data = {$urandom, $urandom};
            #1;
            checks++; if (in_ready !== 8'h00) begin errors++; $display("FAIL bp_ready_%0d got=%b exp=00000000", i, in_ready); end
            tick();
            checks++; if (out_data !== 8'hA5 || out_valid !== 1'b1 || grant_idx !== 3'd3) begin
                errors++; $display("FAIL bp_hold_%0d got=%h/%b/%0d exp=a5/1/3", i, out_data, out_valid, grant_idx); end
        end
        out_ready = 1'b1;
        in_data[3*8 +: 8] = 8'h5A;
        #1;
        checks++; if (in_ready !== 8'h08) begin errors++; $display("FAIL bp_release_ready got=%b exp=00001000", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h5A) begin
            errors++; $display("FAIL bp_no_bubble got=%b/%h exp=1/5a", out_valid, out_data); end
        in_valid = 8'h00;
        tick();
    endtask

    task automatic test_round_robin();
        int exp2 [4] = '{2, 6, 2, 6};
        mode      = 1'b1;
        out_ready = 1'b1;
        in_valid  = 8'hFF;
        for (int k = 0; k < 8; k++) in_data[k*8 +: 8] = 8'(k);
        for (int i = 0; i < 9; i++) begin
            tick();
            checks++; if (out_valid !== 1'b1 || grant_idx !== 3'(i % 8) || out_data !== 8'(i % 8)) begin
                errors++; $display("FAIL rr_all_%0d got=%0d/%h exp=%0d", i, grant_idx, out_data, i % 8); end
        end
        in_valid = 8'h44;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (grant_idx !== 3'(exp2[i])) begin
                errors++; $display("FAIL rr_pair_%0d got=%0d exp=%0d", i, grant_idx, exp2[i]); end
        end
        in_valid = 8'h00;
        tick();
    endtask

    task automatic test_random();
        logic [7:0] er;
        for (int i = 0; i < 400; i++) begin
            mode      = 1'($urandom);
            sel       = 3'($urandom);
            in_valid  = 8'($urandom) & 8'($urandom);
            in_data   = {$urandom, $urandom};
            out_ready = ($urandom_range(0, 9) < 7);
            #1;
            er = exp_ready();
            checks++; if (in_ready !== er) begin errors++; $display("FAIL rand_ready_%0d got=%b exp=%b", i, in_ready, er); end
            tick();
            checks++; if (out_valid !== m_valid || out_data !== m_data || grant_idx !== m_grant) begin
                errors++; $display("FAIL rand_out_%0d got=%b/%h/%0d exp=%b/%h/%0d", i,
                    out_valid, out_data, grant_idx, m_valid, m_data, m_grant); end
`ifdef STREAM_MUX_COUNT_EN
            checks++; if (beat_count !== m_count) begin errors++; $display("FAIL rand_count_%0d got=%0d exp=%0d", i, beat_count, m_count); end
`endif
        end
    endtask

    task automatic test_async_reset();
        mode      = 1'b0;
        sel       = 3'd1;
        in_valid  = 8'h02;
        in_data[1*8 +: 8] = 8'h3C;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ar_pre_valid got=%b exp=1", out_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_data !== 8'h00) begin
            errors++; $display("FAIL ar_immediate got=%b/%h exp=0/00", out_valid, out_data); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        mode      = 1'b1;
        in_valid  = 8'hFF;
        out_ready = 1'b1;
        tick();
        checks++; if (grant_idx !== 3'd0 || out_valid !== 1'b1) begin
            errors++; $display("FAIL ar_rr_restart got=%0d/%b exp=0/1", grant_idx, out_valid); end
        in_valid = 8'h00;
        tick();
    endtask

`ifdef STREAM_MUX_COUNT_EN
    task automatic test_count();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        checks++; if (beat_count !== 16'd0) begin errors++; $display("FAIL count_reset got=%0d exp=0", beat_count); end
        mode      = 1'b0;
        sel       = 3'd0;
        in_valid  = 8'h01;
        out_ready = 1'b1;
        repeat (70001) @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checks++; if (beat_count !== 16'd4464) begin errors++; $display("FAIL count_wrap got=%0d exp=4464", beat_count); end
        repeat (5) @(negedge clk);
        checks++; if (beat_count !== 16'd4464) begin errors++; $display("FAIL count_stall got=%0d exp=4464", beat_count); end
    endtask
`endif

    initial begin
        rst_n     = 1'b0;
        in_data   = '0;
        in_valid  = '0;
        mode      = 1'b0;
        sel       = '0;
        out_ready = 1'b0;
        in9_data  = '0;
        in9_valid = '0;
        sel9      = '0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_fixed();
        test_sel_range();
        test_backpressure();
        test_round_robin();
        test_random();
        test_async_reset();
`ifdef STREAM_MUX_COUNT_EN
        test_count();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
